mux_scan_seq: RTL and testbench
===============================

MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
REQ-001 Parameter WIDTH, default 4, SHALL be the data bits per channel (1..32).
REQ-002 Parameter CHANNELS, default 4, SHALL be the number of input channels (2..16).
REQ-003 Parameter DWELL, default 8, SHALL be the cycles per channel in scan mode (1..256).
REQ-004 Port clk, input, 1, SHALL be the single clock; all state on rising edge.
REQ-005 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-006 Port din, input, CHANNELS*WIDTH, SHALL carry the packed channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 Port sel, input, SELW=max(1,clog2(CHANNELS)), SHALL be the manual channel select.
REQ-008 Port mode, input, 1, SHALL select the operating mode: 0 = manual, 1 = auto-scan.
REQ-009 Port out_ready, input, 1, SHALL be the consumer accept signal.
REQ-010 Port y, output, WIDTH, SHALL be the registered selected data.
REQ-011 Port y_valid, output, 1, SHALL indicate that y holds an unaccepted sample.
REQ-012 Port ch, output, SELW, SHALL be the channel index of the sample in y.
REQ-013 Port wrap, output, 1, SHALL pulse for one cycle when a scan sample from channel CHANNELS-1 is loaded.

Function
REQ-014 A transfer SHALL occur on a cycle with y_valid=1 and out_ready=1.
REQ-015 While y_valid=1 and out_ready=0, y, ch and y_valid SHALL hold stable.
REQ-016 FSM states SHALL be MANUAL, SCAN and STALL; mode is sampled every cycle.
REQ-017 In MANUAL, whenever the output register is empty or transferring, it SHALL load din[sel] with ch=sel and y_valid=1; latency is 1 cycle.
REQ-018 A sel value at or above CHANNELS SHALL load zero data with ch=sel.
REQ-019 In SCAN, the dwell counter SHALL count 0..DWELL-1; at DWELL-1 it SHALL load din[scan_ch] with ch=scan_ch, then advance scan_ch and clear the counter.
REQ-020 scan_ch SHALL wrap from CHANNELS-1 to 0, and wrap SHALL assert in the load cycle of channel CHANNELS-1.
REQ-021 If the dwell ends while y_valid=1 without a transfer, the FSM SHALL enter STALL with the counter frozen at DWELL-1 and scan_ch unchanged.
REQ-022 STALL SHALL load and return to SCAN in the cycle the pending sample transfers; a transfer and a new load in the same cycle SHALL be legal, with y_valid remaining 1.
REQ-023 A mode change 1->0 SHALL go to MANUAL next cycle and discard dwell progress; a pending y sample SHALL be retained until transferred.
REQ-024 A mode change 0->1 SHALL enter SCAN with scan_ch=0 and counter=0.
REQ-025 With DWELL=1, SCAN SHALL load one sample per cycle under continuous out_ready.

Reset
REQ-026 Asserted rst SHALL immediately force y=0, y_valid=0, ch=0, wrap=0, scan_ch=0, counter=0 and state MANUAL, including mid-dwell and mid-stall.
REQ-027 The first load after rst release SHALL occur no earlier than the first rising edge with rst low.

Configuration
REQ-028 Macro MUX_SCAN_SEQ_PARITY_EN, when defined, SHALL add output y_par (1 bit) equal to the even parity (XOR) of y, registered together with y and reset to 0.
REQ-029 Without MUX_SCAN_SEQ_PARITY_EN, port y_par and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package mux_pkg SHALL hold the FSM state typedef (MANUAL, SCAN, STALL) and the SELW width function.
REQ-031 Sub-module mux_n_1 (combinational, parameters WIDTH/CHANNELS, out-of-range select yields 0) SHALL perform channel selection.

Verification
REQ-032 Manual: WIDTH=4, CHANNELS=4, din=0x4321, sel=2, out_ready=1 -> y=0x3 and ch=2 one cycle later; sel=3 -> y=0x4.
REQ-033 Scan: DWELL=3, out_ready=1 -> samples 1,2,3,4 at 3-cycle intervals, then channel 0 again; wrap=1 only with channel 3.
REQ-034 Backpressure: out_ready=0 for 10 cycles in SCAN -> single held sample, FSM in STALL; out_ready=1 -> held sample transfers, next channel loads the same cycle.
REQ-035 Reset mid-stall: rst pulsed for 1 cycle -> all outputs 0 asynchronously; after release with mode=1, scan restarts at channel 0.
REQ-036 Mode switch: SCAN at channel 2 mid-dwell, mode->0 with sel=1 -> next load is channel 1; return to mode=1 -> scan restarts at channel 0.
REQ-037 Parity build: y=0xB with MUX_SCAN_SEQ_PARITY_EN defined -> y_par=1; CHANNELS=5 and sel=7 -> y=0, y_par=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the channel scan multiplexer.
package mux_pkg;

  typedef enum logic [1:0] {MANUAL, SCAN, STALL} state_e;

  // Select width, never below one bit so a 1-channel select still has a port.
  function automatic int selw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational N:1 channel selector; a select outside 0..CHANNELS-1 yields zero.
module mux_n_1 import mux_pkg::*; #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SELW    = selw(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          dout
);

  always_comb begin
    dout = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (sel == SELW'(k)) dout = din[k*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Manual/auto-scan channel sequencer with a registered, back-pressured output.
// Optional y_par output (even parity of y) when MUX_SCAN_SEQ_PARITY_EN is defined.
module mux_scan_seq import mux_pkg::*; #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 8,
  localparam int SELW    = selw(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SELW-1:0]           ch,
  output logic                      wrap
`ifdef MUX_SCAN_SEQ_PARITY_EN
  , output logic                    y_par
`endif
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST  = SELW'(CHANNELS - 1);

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0]   scan_q, scan_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic              vld_q, vld_d;
  logic              wrap_q, wrap_d;
  logic              man_load, scan_load;
  logic              can_load;
  logic [SELW-1:0]   mux_sel;
  logic [WIDTH-1:0]  mux_out;

  // The output slot is free when empty or draining this cycle.
  assign can_load = !vld_q || out_ready;
  assign mux_sel  = (state_q == MANUAL) ? sel : scan_q;

  mux_n_1 #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_mux (
    .din  (din),
    .sel  (mux_sel),
    .dout (mux_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scan_d    = scan_q;
    y_d       = y_q;
    ch_d      = ch_q;
    vld_d     = vld_q && !out_ready;
    wrap_d    = 1'b0;
    man_load  = 1'b0;
    scan_load = 1'b0;
    case (state_q)
      MANUAL: begin
        if (mode) begin
          state_d = SCAN;
          cnt_d   = '0;
          scan_d  = '0;
        end else if (can_load) begin
          man_load = 1'b1;
        end
      end
      SCAN, STALL: begin
        // Leaving scan drops dwell progress but keeps any pending sample.
        if (!mode) begin
          state_d = MANUAL;
          cnt_d   = '0;
          scan_d  = '0;
        end else if (state_q == STALL || cnt_q == CNT_LAST) begin
          if (can_load) begin
            scan_load = 1'b1;
            state_d   = SCAN;
          end else begin
            state_d = STALL;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = MANUAL;
    endcase
    if (man_load || scan_load) begin
      y_d   = mux_out;
      ch_d  = mux_sel;
      vld_d = 1'b1;
    end
    if (scan_load) begin
      wrap_d = (scan_q == CH_LAST);
      scan_d = (scan_q == CH_LAST) ? '0 : scan_q + SELW'(1);
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MANUAL;
      cnt_q   <= '0;
      scan_q  <= '0;
      y_q     <= '0;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef MUX_SCAN_SEQ_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= ^y_d;
  end
  assign y_par = par_q;
`endif

  assign y       = y_q;
  assign ch      = ch_q;
  assign y_valid = vld_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench for mux_scan_seq: 4x4-bit DUT with DWELL=3, plus a 5-channel DWELL=1 DUT.
module tb_mux_scan_seq;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] din;
  logic [1:0]  sel, ch;
  logic        mode, out_ready, y_valid, wrap;
  logic [3:0]  y;
  logic [19:0] din5;
  logic [2:0]  sel5, ch5;
  logic        mode5, rdy5, yv5, wrap5;
  logic [3:0]  y5;
`ifdef MUX_SCAN_SEQ_PARITY_EN
  logic        y_par, y_par5;
`endif

  mux_scan_seq #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u_dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .out_ready(out_ready),
    .y(y), .y_valid(y_valid), .ch(ch), .wrap(wrap)
`ifdef MUX_SCAN_SEQ_PARITY_EN
    , .y_par(y_par)
`endif
  );

  mux_scan_seq #(.WIDTH(4), .CHANNELS(5), .DWELL(1)) u_dut5 (
    .clk(clk), .rst(rst), .din(din5), .sel(sel5), .mode(mode5), .out_ready(rdy5),
    .y(y5), .y_valid(yv5), .ch(ch5), .wrap(wrap5)
`ifdef MUX_SCAN_SEQ_PARITY_EN
    , .y_par(y_par5)
`endif
  );

  typedef struct {int c; int v;} exp_t;
  exp_t sb[$];
  exp_t e;
  int   xt[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0, wrap_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input int v);
    sb.push_back('{c, v});
  endtask

  task automatic wait_empty(input string tag, input int max);
    int k = 0;
    while (sb.size() != 0 && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are popped against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (!rst && wrap) begin
      wrap_cnt++;
      chk("wrap_ch", 32'(ch), 3);
    end
    if (!rst && y_valid && out_ready) begin
      xt.push_back(cyc);
      if (sb.size() == 0) chk("sb_unexpected", 32'(ch), 32'hffff_ffff);
      else begin
        e = sb.pop_front();
        chk("sb_ch", 32'(ch), e.c);
        chk("sb_y", 32'(y), e.v);
      end
    end
`ifdef MUX_SCAN_SEQ_PARITY_EN
    if (!rst) begin
      chk("y_par", 32'(y_par), 32'(^y));
      chk("y_par5", 32'(y_par5), 32'(^y5));
    end
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    din = 16'h4321; sel = 2'd2; mode = 1'b0; out_ready = 1'b0;
    din5 = 20'h54321; sel5 = 3'd7; mode5 = 1'b0; rdy5 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_y", 32'(y), 0);
    chk("rst_vld", 32'(y_valid), 0);
    chk("rst_ch", 32'(ch), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_state", 32'(u_dut.state_q), 32'(MANUAL));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) chk("no_early_load", 32'(y_valid), 0);

    // Manual: sel=2 then sel=3 on the 0x4321 pattern.
    @(posedge clk);
    @(negedge clk);
    chk("man_y", 32'(y), 3);
    chk("man_ch", 32'(ch), 2);
    chk("man_vld", 32'(y_valid), 1);
    push(2, 3);
    @(posedge clk); #1;
    sel = 2'd3; out_ready = 1'b1;
    push(3, 4);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("man3_y", 32'(y), 4);
    chk("man3_ch", 32'(ch), 3);

    // Auto-scan with continuous ready: channels 0..3 then 0, one every 3 cycles.
    @(posedge clk); #1;
    mode = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    xt.delete();
    wrap_cnt = 0;
    push(0, 1); push(1, 2); push(2, 3); push(3, 4); push(0, 1);
    wait_empty("scan", 40);
    chk("scan_xfers", xt.size(), 5);
    if (xt.size() == 5)
      for (int i = 1; i < 5; i++) chk("scan_interval", xt[i] - xt[i-1], 3);
    chk("wrap_count", wrap_cnt, 1);

    // Backpressure: next channel (1) loads and is held, FSM stalls.
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_state", 32'(u_dut.state_q), 32'(STALL));
    chk("bp_vld", 32'(y_valid), 1);
    chk("bp_ch", 32'(ch), 1);
    chk("bp_y", 32'(y), 2);
    push(1, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_next_vld", 32'(y_valid), 1);
    chk("bp_next_ch", 32'(ch), 2);
    chk("bp_next_y", 32'(y), 3);
    chk("bp_next_state", 32'(u_dut.state_q), 32'(SCAN));

    // Reset in the middle of a stall.
    repeat (6) @(posedge clk);
    #1;
    chk("stall2_state", 32'(u_dut.state_q), 32'(STALL));
    rst = 1'b1;
    #1;
    chk("rstm_y", 32'(y), 0);
    chk("rstm_vld", 32'(y_valid), 0);
    chk("rstm_ch", 32'(ch), 0);
    chk("rstm_state", 32'(u_dut.state_q), 32'(MANUAL));
    chk("rstm_cnt", 32'(u_dut.cnt_q), 0);
    chk("rstm_scan", 32'(u_dut.scan_q), 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    push(0, 1);
    wait_empty("restart", 20);
    push(1, 2);
    wait_empty("scan2", 20);

    // Mode switch mid-dwell on channel 2: manual sel=1, then scan restarts at 0.
    mode = 1'b0; sel = 2'd1; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("ms_ch", 32'(ch), 1);
    chk("ms_y", 32'(y), 2);
    chk("ms_vld", 32'(y_valid), 1);
    chk("ms_state", 32'(u_dut.state_q), 32'(MANUAL));
    @(posedge clk); #1;
    push(1, 2); push(0, 1);
    mode = 1'b1; out_ready = 1'b1;
    wait_empty("rescan", 20);
    out_ready = 1'b0;

    // Second DUT: out-of-range select, then DWELL=1 one sample per cycle.
    chk("oor_y", 32'(y5), 0);
    chk("oor_ch", 32'(ch5), 7);
    chk("oor_vld", 32'(yv5), 1);
    mode5 = 1'b1; rdy5 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("d1_ch", 32'(ch5), k % 5);
      chk("d1_y", 32'(y5), (k % 5) + 1);
      chk("d1_vld", 32'(yv5), 1);
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
